// File: rtl/ov_power_seq.sv
// OV camera power-up / bring-up sequencer: PWDN -> RST -> SETTLE -> config.
// Build option: define OV_SEQ_TIMEOUT_EN to bound CFG_WAIT by CFG_TIMEOUT.
module ov_power_seq #(
  parameter logic [19:0] PWDN_CYC    = 20'd1000,
  parameter logic [19:0] RST_CYC     = 20'd1000,
  parameter logic [19:0] SETTLE_CYC  = 20'hffff0,
  parameter logic [19:0] CFG_TIMEOUT = 20'hfffff,
  parameter logic [1:0]  MAX_RETRY   = 2'd3
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       restart_i,
  input  logic       cfg_done_i,
  input  logic       cfg_err_i,
  output logic       cam_pwdn_o,
  output logic       cam_rst_n_o,
  output logic       cfg_start_o,
  output logic       capture_en_o,
  output logic       ready_o,
  output logic       fail_o,
  output logic [1:0] retry_cnt_o
);

  typedef enum logic [2:0] {
    S_PWDN,
    S_RST,
    S_SETTLE,
    S_START,
    S_WAIT,
    S_RUN,
    S_FAIL
  } state_t;

  // A zero length is treated as a one-cycle phase.
  localparam logic [19:0] PWDN_END =
    (PWDN_CYC == 20'd0) ? 20'd0 : PWDN_CYC - 20'd1;
  localparam logic [19:0] RST_END =
    (RST_CYC == 20'd0) ? 20'd0 : RST_CYC - 20'd1;
  localparam logic [19:0] SET_END =
    (SETTLE_CYC == 20'd0) ? 20'd0 : SETTLE_CYC - 20'd1;

  state_t      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [1:0]  retry_d;
  logic        cfg_fail;
  logic        pwdn_d, rst_n_d, start_d;
  logic        cap_d, ready_d, fail_d;

`ifdef OV_SEQ_TIMEOUT_EN
  localparam logic [19:0] TO_END =
    (CFG_TIMEOUT == 20'd0) ? 20'd0 : CFG_TIMEOUT - 20'd1;
  // Silence from the config engine past the budget is an error.
  always_comb begin
    cfg_fail = cfg_err_i;
    if (!cfg_done_i && cnt_q == TO_END)
      cfg_fail = 1'b1;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^CFG_TIMEOUT;
  // Without the timeout only the engine's error ends a wait badly.
  always_comb begin
    cfg_fail = cfg_err_i;
  end
`endif

  // Next state, retry count and phase counter.
  always_comb begin
    state_d = state_q;
    retry_d = retry_cnt_o;
    if (restart_i) begin
      state_d = S_PWDN;
      retry_d = 2'd0;
    end else begin
      unique case (state_q)
        S_PWDN:   if (cnt_q == PWDN_END) state_d = S_RST;
        S_RST:    if (cnt_q == RST_END) state_d = S_SETTLE;
        S_SETTLE: if (cnt_q == SET_END) state_d = S_START;
        S_START:  state_d = S_WAIT;
        S_WAIT: begin
          if (cfg_fail) begin
            if (retry_cnt_o < MAX_RETRY) begin
              retry_d = retry_cnt_o + 2'd1;
              state_d = S_PWDN;
            end else begin
              state_d = S_FAIL;
            end
          end else if (cfg_done_i) begin
            state_d = S_RUN;
          end
        end
        S_RUN:    state_d = S_RUN;
        S_FAIL:   state_d = S_FAIL;
        default:  state_d = S_PWDN;
      endcase
    end
    cnt_d = cnt_q + 20'd1;
    if (restart_i || state_d != state_q)
      cnt_d = 20'd0;
  end

  // Pin levels for the state being entered, so outputs track the state edge.
  always_comb begin
    pwdn_d  = 1'b0;
    rst_n_d = 1'b1;
    start_d = 1'b0;
    cap_d   = 1'b0;
    ready_d = 1'b0;
    fail_d  = 1'b0;
    unique case (state_d)
      S_PWDN: begin
        pwdn_d  = 1'b1;
        rst_n_d = 1'b0;
      end
      S_RST:   rst_n_d = 1'b0;
      S_START: start_d = 1'b1;
      S_RUN: begin
        cap_d   = 1'b1;
        ready_d = 1'b1;
      end
      S_FAIL: begin
        pwdn_d  = 1'b1;
        rst_n_d = 1'b0;
        fail_d  = 1'b1;
      end
      default: ;
    endcase
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= S_PWDN;
      cnt_q        <= 20'd0;
      retry_cnt_o  <= 2'd0;
      cam_pwdn_o   <= 1'b1;
      cam_rst_n_o  <= 1'b0;
      cfg_start_o  <= 1'b0;
      capture_en_o <= 1'b0;
      ready_o      <= 1'b0;
      fail_o       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_cnt_o  <= retry_d;
      cam_pwdn_o   <= pwdn_d;
      cam_rst_n_o  <= rst_n_d;
      cfg_start_o  <= start_d;
      capture_en_o <= cap_d;
      ready_o      <= ready_d;
      fail_o       <= fail_d;
    end
  end

endmodule

// File: tb/tb_ov_power_seq.sv
// Scoreboard bench for ov_power_seq.
// Expected pin vectors are queued per edge and compared at the next negedge.
module tb_ov_power_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       restart = 1'b0;
  logic       done = 1'b0;
  logic       err = 1'b0;
  logic       pwdn, cam_rst_n, start, cap, ready, fail;
  logic [1:0] retry;
  logic [7:0] outs;

  typedef struct {
    int         cyc;
    logic [7:0] val;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  // bits: pwdn rst_n start cap ready fail retry[1:0]
  localparam logic [7:0] O_PWDN  = 8'b1000_0000;
  localparam logic [7:0] O_RST   = 8'b0000_0000;
  localparam logic [7:0] O_SET   = 8'b0100_0000;
  localparam logic [7:0] O_START = 8'b0110_0000;
  localparam logic [7:0] O_WAIT  = 8'b0100_0000;
  localparam logic [7:0] O_RUN   = 8'b0101_1000;
  localparam logic [7:0] O_FAIL  = 8'b1000_0100;

  ov_power_seq #(
    .PWDN_CYC   (20'd4),
    .RST_CYC    (20'd3),
    .SETTLE_CYC (20'd5),
    .CFG_TIMEOUT(20'd20),
    .MAX_RETRY  (2'd2)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .restart_i   (restart),
    .cfg_done_i  (done),
    .cfg_err_i   (err),
    .cam_pwdn_o  (pwdn),
    .cam_rst_n_o (cam_rst_n),
    .cfg_start_o (start),
    .capture_en_o(cap),
    .ready_o     (ready),
    .fail_o      (fail),
    .retry_cnt_o (retry)
  );

  assign outs = {pwdn, cam_rst_n, start, cap, ready, fail, retry};

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at edge %0d", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [7:0] r(logic [7:0] v, logic [1:0] n);
    return v | {6'b0, n};
  endfunction

  // Sorted insert so entries may be queued in any order.
  task automatic exp_at(int c, logic [7:0] v, string tag);
    exp_t e;
    int   i;
    e.cyc = c;
    e.val = v;
    e.tag = tag;
    i = 0;
    while (i < sb.size() && sb[i].cyc <= c) i++;
    sb.insert(i, e);
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      if (e.cyc < cyc) chk({e.tag, "_late"}, cyc, e.cyc);
      else chk(e.tag, {24'b0, outs}, {24'b0, e.val});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(int c);
    while (cyc < c) step();
  endtask

  // Phases of one bring-up when PWDN holds with cnt=0 after edge b.
  task automatic push_seq(int b, logic [1:0] n);
    exp_at(b + 1,  r(O_PWDN, n),  "pwdn_hold");
    exp_at(b + 3,  r(O_PWDN, n),  "pwdn_end");
    exp_at(b + 4,  r(O_RST, n),   "rst_begin");
    exp_at(b + 6,  r(O_RST, n),   "rst_end");
    exp_at(b + 7,  r(O_SET, n),   "settle_begin");
    exp_at(b + 11, r(O_SET, n),   "settle_end");
    exp_at(b + 12, r(O_START, n), "start_pulse");
    exp_at(b + 13, r(O_WAIT, n),  "start_clear");
  endtask

  task automatic do_restart(output int b);
    restart = 1'b1;
    step();
    restart = 1'b0;
    b = cyc;
    exp_at(b, O_PWDN, "restart_pwdn");
  endtask

  // Input asserted so that the edge numbered s samples it.
  task automatic pulse(int s, logic d, logic e);
    run_to(s - 1);
    done = d;
    err = e;
    step();
    done = 1'b0;
    err = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, b2, b3;
    step();
    step();
    chk("reset_vals", {24'b0, outs}, {24'b0, O_PWDN});

    // Nominal bring-up
    rst_n = 1'b1;
    b = cyc;
    push_seq(b, 2'd0);
    exp_at(b + 17, O_WAIT, "wait_hold");
    exp_at(b + 18, O_RUN, "run");
    exp_at(b + 25, O_RUN, "run_hold");
    pulse(b + 18, 1'b1, 1'b0);
    run_to(b + 26);

    // Restart from RUN, then one error before success
    do_restart(b);
    push_seq(b, 2'd0);
    exp_at(b + 14, O_WAIT, "err_pre");
    exp_at(b + 15, r(O_PWDN, 2'd1), "err_retry1");
    pulse(b + 15, 1'b0, 1'b1);
    b2 = b + 15;
    push_seq(b2, 2'd1);
    exp_at(b2 + 14, r(O_RUN, 2'd1), "run_retry1");
    pulse(b2 + 14, 1'b1, 1'b0);
    run_to(b2 + 16);

    // Done ignored in SETTLE; done+err counts as error; exhaustion
    do_restart(b);
    push_seq(b, 2'd0);
    exp_at(b + 10, O_SET, "settle_ign_done");
    pulse(b + 9, 1'b1, 1'b0);
    exp_at(b + 14, r(O_PWDN, 2'd1), "both_err_wins");
    pulse(b + 14, 1'b1, 1'b1);
    b2 = b + 14;
    push_seq(b2, 2'd1);
    exp_at(b2 + 14, r(O_PWDN, 2'd2), "err_retry2");
    pulse(b2 + 14, 1'b0, 1'b1);
    b3 = b2 + 14;
    push_seq(b3, 2'd2);
    exp_at(b3 + 14, r(O_FAIL, 2'd2), "fail");
    exp_at(b3 + 20, r(O_FAIL, 2'd2), "fail_hold");
    pulse(b3 + 14, 1'b0, 1'b1);
    run_to(b3 + 21);
    do_restart(b);

    // Async reset in the RST phase, then nominal again
    exp_at(b + 1, O_PWDN, "pre_rst_pwdn");
    exp_at(b + 4, O_RST, "pre_rst_rst");
    run_to(b + 5);
    rst_n = 1'b0;
    #1;
    chk("async_rst", {24'b0, outs}, {24'b0, O_PWDN});
    step();
    step();
    rst_n = 1'b1;
    b = cyc;
    push_seq(b, 2'd0);
    exp_at(b + 18, O_RUN, "run_after_rst");
    pulse(b + 18, 1'b1, 1'b0);
    run_to(b + 19);

    // Wait behaviour with no response from the config engine
    do_restart(b);
    push_seq(b, 2'd0);
`ifdef OV_SEQ_TIMEOUT_EN
    exp_at(b + 32, O_WAIT, "to_pre");
    exp_at(b + 33, r(O_PWDN, 2'd1), "to_retry");
    run_to(b + 34);
`else
    exp_at(b + 1013, O_WAIT, "no_timeout");
    exp_at(b + 1100, O_WAIT, "no_timeout_hold");
    run_to(b + 1101);
`endif

    step();
    chk("sb_drain", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
